// File: rtl/pwm_fade_sequencer_pkg.sv
// pwm_pkg: shared types and default widths for the PWM fade sequencer.
//   ch_state_t  per-channel sequencer state (idle / ramping)
//   fade_cmd_t  one fade command (target level, step size, rate divider)
//               at the default CW/DW widths
package pwm_pkg;

    localparam int unsigned CW_DEFAULT = 16;
    localparam int unsigned DW_DEFAULT = 8;

    typedef enum logic {
        CH_IDLE,
        CH_RAMP
    } ch_state_t;

    typedef struct packed {
        logic [CW_DEFAULT-1:0] target;
        logic [CW_DEFAULT-1:0] step;
        logic [DW_DEFAULT-1:0] div;
    } fade_cmd_t;

endpackage

// File: rtl/pwm_fade_sequencer_channel.sv
// pwm_fade_channel: one fade channel of the PWM fade sequencer.
// Holds the channel's level, latched command, rate divider and the compare
// register that feeds a PWM generator. Compare is reloaded only on
// period_tick, so each PWM period sees a constant compare value.
// Optional feature: `PWM_GAMMA_EN squares the level (level*level >> CW)
// into compare, registered one cycle after the period_tick load.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   period_tick   one-cycle pulse at PWM counter wrap
//   accept        command for this channel accepted this cycle
//   cmd_target    target level to ramp toward
//   cmd_step      level change per step (0 treated as 1)
//   cmd_div       period_ticks between steps, minus 1
//   compare       compare value for the PWM generator
//   busy          channel is ramping
//   done          one-cycle pulse when the target is reached
module pwm_fade_channel
    import pwm_pkg::*;
#(
    parameter int unsigned CW = CW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          period_tick,
    input  logic          accept,
    input  logic [CW-1:0] cmd_target,
    input  logic [CW-1:0] cmd_step,
    input  logic [DW-1:0] cmd_div,
    output logic [CW-1:0] compare,
    output logic          busy,
    output logic          done
);

    ch_state_t     state, state_n;
    logic [CW-1:0] level, level_n;
    logic [CW-1:0] tgt, tgt_n;
    logic [CW-1:0] step, step_n;
    logic [DW-1:0] div, div_n;
    logic [DW-1:0] divcnt, divcnt_n;
    logic          done_n;
    logic [CW-1:0] cmp_src;

    logic [CW:0]   sum;
    logic [CW-1:0] stepped;

    // One step toward the target, clamped at the target. The rising sum is
    // kept one bit wider so it cannot wrap past the top of the range.
    always_comb begin
        sum = {1'b0, level} + {1'b0, step};
        if (tgt > level) begin
            stepped = (sum >= {1'b0, tgt}) ? tgt : sum[CW-1:0];
        end else if ((level < step) || ((level - step) <= tgt)) begin
            stepped = tgt;
        end else begin
            stepped = level - step;
        end
    end

    always_comb begin
        state_n  = state;
        level_n  = level;
        tgt_n    = tgt;
        step_n   = step;
        div_n    = div;
        divcnt_n = divcnt;
        done_n   = 1'b0;
        case (state)
            CH_IDLE: begin
                if (accept) begin
                    tgt_n    = cmd_target;
                    step_n   = (cmd_step == '0) ? CW'(1) : cmd_step;
                    div_n    = cmd_div;
                    divcnt_n = '0;
                    state_n  = CH_RAMP;
                end
            end
            CH_RAMP: begin
                if (period_tick) begin
                    if (divcnt == div) begin
                        divcnt_n = '0;
                        level_n  = stepped;
                    end else begin
                        divcnt_n = divcnt + DW'(1);
                    end
                end
                // Also covers a command whose target equals the current
                // level: one cycle in RAMP, then done without any step.
                if (level_n == tgt) begin
                    state_n = CH_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = CH_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= CH_IDLE;
            level   <= '0;
            tgt     <= '0;
            step    <= '0;
            div     <= '0;
            divcnt  <= '0;
            done    <= 1'b0;
            cmp_src <= '0;
        end else begin
            state   <= state_n;
            level   <= level_n;
            tgt     <= tgt_n;
            step    <= step_n;
            div     <= div_n;
            divcnt  <= divcnt_n;
            done    <= done_n;
            // Load the post-step level so a step reaches compare on the
            // same edge the PWM counter wraps.
            if (period_tick) begin
                cmp_src <= level_n;
            end
        end
    end

    assign busy = (state == CH_RAMP);

`ifdef PWM_GAMMA_EN
    logic [2*CW-1:0] square;

    assign square = {{CW{1'b0}}, cmp_src} * {{CW{1'b0}}, cmp_src};

    always_ff @(posedge CLK) begin
        if (RST) begin
            compare <= '0;
        end else begin
            compare <= square[2*CW-1:CW];
        end
    end
`else
    assign compare = cmp_src;
`endif

endmodule

// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer: sequences the compare values of NUM_CH PWM generators
// so LEDs fade between brightness levels without CPU intervention.
// Optional feature: `PWM_GAMMA_EN applies a square-law gamma curve to the
// compare outputs (one extra cycle of compare latency).
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   period_tick  one-cycle pulse when the PWM counter wraps to 0
//   cmd_valid    fade command present
//   cmd_ready    command can be accepted (channel idle, not in reset)
//   cmd_ch       target channel index (out-of-range commands are dropped)
//   cmd_target   target level
//   cmd_step     level change per step (0 treated as 1)
//   cmd_div      period_ticks between steps, minus 1
//   compare      per-channel compare values, channel i at [i*CW +: CW]
//   busy         per-channel ramping flag
//   done         per-channel one-cycle pulse on reaching target
module pwm_fade_sequencer
    import pwm_pkg::*;
#(
    parameter  int unsigned NUM_CH = 2,
    parameter  int unsigned CW     = CW_DEFAULT,
    parameter  int unsigned DW     = DW_DEFAULT,
    localparam int unsigned CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 period_tick,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CHW-1:0]       cmd_ch,
    input  logic [CW-1:0]        cmd_target,
    input  logic [CW-1:0]        cmd_step,
    input  logic [DW-1:0]        cmd_div,
    output logic [NUM_CH*CW-1:0] compare,
    output logic [NUM_CH-1:0]    busy,
    output logic [NUM_CH-1:0]    done
);

    logic          ch_in_range;
    logic [CW-1:0] ch_compare [NUM_CH];

    assign ch_in_range = ({{(32-CHW){1'b0}}, cmd_ch} < 32'(NUM_CH));

    // Out-of-range channels report ready so the sender is never stalled;
    // such commands match no channel and are dropped.
    always_comb begin
        cmd_ready = 1'b0;
        if (!RST) begin
            cmd_ready = ch_in_range ? ~busy[cmd_ch] : 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic accept;

        assign accept = cmd_valid & cmd_ready & ch_in_range & (cmd_ch == CHW'(i));

        pwm_fade_channel #(
            .CW (CW),
            .DW (DW)
        ) u_ch (
            .CLK         (CLK),
            .RST         (RST),
            .period_tick (period_tick),
            .accept      (accept),
            .cmd_target  (cmd_target),
            .cmd_step    (cmd_step),
            .cmd_div     (cmd_div),
            .compare     (ch_compare[i]),
            .busy        (busy[i]),
            .done        (done[i])
        );

        assign compare[i*CW +: CW] = ch_compare[i];
    end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Testbench for pwm_fade_sequencer (NUM_CH=2, CW=16, DW=8).
// The stimulus process pushes the expected post-tick state into a queue
// before each period_tick; a monitor pops one entry per tick and compares.
module tb_pwm_fade_sequencer;
    import pwm_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        period_tick = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [0:0]  cmd_ch = '0;
    logic [15:0] cmd_target = '0;
    logic [15:0] cmd_step = '0;
    logic [7:0]  cmd_div = '0;
    logic [31:0] compare;
    logic [1:0]  busy;
    logic [1:0]  done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          lvl0;
        int          lvl1;
        logic [1:0]  busy;
        logic [1:0]  done;
    } exp_t;

    exp_t exp_q[$];

    pwm_fade_sequencer #(
        .NUM_CH (2),
        .CW     (16),
        .DW     (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .period_tick (period_tick),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ch      (cmd_ch),
        .cmd_target  (cmd_target),
        .cmd_step    (cmd_step),
        .cmd_div     (cmd_div),
        .compare     (compare),
        .busy        (busy),
        .done        (done)
    );

    always #5 CLK = ~CLK;

    // Expected compare value for a given channel level.
    function automatic int model_cmp(input int lvl);
`ifdef PWM_GAMMA_EN
        longint sq;
        sq = longint'(lvl) * longint'(lvl);
        return int'(sq >> 16);
`else
        return lvl;
`endif
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic tick(input string tag, input int l0, input int l1,
                        input logic [1:0] b, input logic [1:0] d);
        exp_t e;
        e.tag = tag; e.lvl0 = l0; e.lvl1 = l1; e.busy = b; e.done = d;
        exp_q.push_back(e);
        @(negedge CLK);
        period_tick = 1'b1;
        @(negedge CLK);
        period_tick = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic send_cmd(input int ch, input int tgt, input int stp, input int dv);
        bit ok;
        ok = 1'b0;
        @(negedge CLK);
        cmd_ch     = 1'(ch);
        cmd_target = 16'(tgt);
        cmd_step   = 16'(stp);
        cmd_div    = 8'(dv);
        cmd_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        @(negedge CLK);
        cmd_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cmd_accept ch%0d: got not-ready for 20 cycles, expected ready", ch);
        end
    endtask

    // Monitor: one queue entry per period_tick.
    initial begin
        exp_t e;
        logic [1:0]  b_s, d_s;
        forever begin
            @(posedge CLK iff period_tick === 1'b1);
            #1;
            b_s = busy;
            d_s = done;
`ifdef PWM_GAMMA_EN
            @(posedge CLK);
            #1;
`endif
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor: got tick with no expectation, expected queued entry");
            end else begin
                e = exp_q.pop_front();
                chk({e.tag, " compare0"}, int'(compare[15:0]), model_cmp(e.lvl0));
                chk({e.tag, " compare1"}, int'(compare[31:16]), model_cmp(e.lvl1));
                chk({e.tag, " busy"}, int'(b_s), int'(e.busy));
                chk({e.tag, " done"}, int'(d_s), int'(e.done));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        cmd_valid = 1'b0;
        chk("rst cmd_ready", int'(cmd_ready), 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("reset compare", int'(compare), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset cmd_ready", int'(cmd_ready), 1);

        for (int i = 0; i < 10; i++) tick("idle", 0, 0, 2'b00, 2'b00);

        // ch0 rising: 256 per tick up to 1024
        send_cmd(0, 1024, 256, 0);
        chk("ch0 busy after accept", int'(busy), 1);
        tick("up1", 256, 0, 2'b01, 2'b00);
        tick("up2", 512, 0, 2'b01, 2'b00);
        tick("up3", 768, 0, 2'b01, 2'b00);
        tick("up4", 1024, 0, 2'b00, 2'b01);

        // ch1 to 1000, then falling with div=2 and a final partial step
        send_cmd(1, 1000, 1000, 0);
        tick("ch1 set", 1024, 1000, 2'b00, 2'b10);
        send_cmd(1, 0, 300, 2);
        tick("dn t1", 1024, 1000, 2'b10, 2'b00);
        tick("dn t2", 1024, 1000, 2'b10, 2'b00);
        tick("dn t3", 1024, 700, 2'b10, 2'b00);
        tick("dn t4", 1024, 700, 2'b10, 2'b00);
        tick("dn t5", 1024, 700, 2'b10, 2'b00);
        tick("dn t6", 1024, 400, 2'b10, 2'b00);
        tick("dn t7", 1024, 400, 2'b10, 2'b00);
        tick("dn t8", 1024, 400, 2'b10, 2'b00);
        tick("dn t9", 1024, 100, 2'b10, 2'b00);
        tick("dn t10", 1024, 100, 2'b10, 2'b00);
        tick("dn t11", 1024, 100, 2'b10, 2'b00);
        tick("dn t12", 1024, 0, 2'b00, 2'b10);

        // Saturation: 65000 + 1000 clamps to 65535, no wrap
        send_cmd(0, 65000, 65535, 0);
        tick("sat pre", 65000, 0, 2'b00, 2'b01);
        send_cmd(0, 65535, 1000, 0);
        tick("sat", 65535, 0, 2'b00, 2'b01);

        // Target equal to level: done after one cycle, compare unchanged
        send_cmd(0, 65535, 5, 0);
        @(negedge CLK);
        chk("eq busy", int'(busy), 0);
        tick("eq", 65535, 0, 2'b00, 2'b00);

        // Contention: ch0 ramps, held ch0 command is refused
        send_cmd(0, 64535, 500, 0);
        @(negedge CLK);
        cmd_ch = 1'b0; cmd_target = 16'd0; cmd_step = 16'd1; cmd_div = 8'd0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("held ch0 cmd_ready", int'(cmd_ready), 0);
        end
        // ch1 command lands on the same cycle as a tick
        begin
            exp_t e;
            e.tag = "coinc"; e.lvl0 = 65035; e.lvl1 = 0; e.busy = 2'b11; e.done = 2'b00;
            exp_q.push_back(e);
        end
        cmd_ch = 1'b1; cmd_target = 16'd300; cmd_step = 16'd300; cmd_div = 8'd0;
        period_tick = 1'b1;
        #1;
        chk("coinc cmd_ready", int'(cmd_ready), 1);
        @(negedge CLK);
        cmd_valid = 1'b0;
        period_tick = 1'b0;
        repeat (3) @(negedge CLK);
        tick("both done", 64535, 300, 2'b00, 2'b11);

        // Gamma point: ch1 to 32768
        send_cmd(1, 32768, 65535, 0);
        tick("half", 64535, 32768, 2'b00, 2'b10);

        // Reset mid-ramp at level 512
        send_cmd(0, 0, 65535, 0);
        tick("to zero", 0, 32768, 2'b00, 2'b01);
        send_cmd(0, 1024, 512, 0);
        tick("mid", 512, 32768, 2'b01, 2'b00);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst cmd_ready comb", int'(cmd_ready), 0);
        @(negedge CLK);
        RST = 1'b0;
        chk("midrst compare", int'(compare), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("midrst no done", int'(done), 0);
        end

        repeat (5) @(negedge CLK);
        chk("queue drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
